// File: rtl/hilo_controller.sv
// rtl/hilo_controller.sv - MIPS HI/LO register owner and multiply/divide unit sequencer
module hilo_controller #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        timeout_err,
  output logic        div_valid_in,
  output logic        div_sign,
  output logic [31:0] div_src_a,
  output logic [31:0] div_src_b,
  input  logic        div_valid_out,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mul_valid_in,
  output logic        mul_sign,
  output logic [31:0] mul_src_a,
  output logic [31:0] mul_src_b,
  input  logic        mul_valid_out,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DRAIN} state_t;

  localparam int              WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]   WDOG_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t        state, state_nxt;
  logic [WW-1:0] wdog_cnt;
  logic [31:0]   hi_q, lo_q, opa_q, opb_q;
  logic          accept, is_mul, is_div, div_ok, in_busy;
  logic          wdog_hit, div_done, mul_done, aborting;

  always_comb begin
    accept    = op_valid && (state == IDLE);
    is_mul    = (op_code == OP_MULT) || (op_code == OP_MULTU);
    is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
    div_ok    = is_div && (src_b != 32'd0);
    in_busy   = (state == MUL_BUSY) || (state == DIV_BUSY);
    wdog_hit  = (wdog_cnt == WDOG_LAST);
    div_done  = (state == DIV_BUSY) && div_valid_out;
    mul_done  = (state == MUL_BUSY) && mul_valid_out;
    // A unit result arriving on the watchdog's last cycle still counts as a completion.
    aborting  = in_busy && wdog_hit && !div_done && !mul_done;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL_BUSY;
        else if (accept && div_ok) state_nxt = DIV_BUSY;
      end
      MUL_BUSY: if (mul_valid_out || wdog_hit) state_nxt = DRAIN;
      DIV_BUSY: if (div_valid_out || wdog_hit) state_nxt = DRAIN;
      DRAIN:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      div_valid_in <= 1'b0;
      mul_valid_in <= 1'b0;
      div_sign     <= 1'b0;
      mul_sign     <= 1'b0;
      timeout_err  <= 1'b0;
      wdog_cnt     <= '0;
    end else begin
      if (in_busy) wdog_cnt <= wdog_cnt + 1'b1;
      else         wdog_cnt <= '0;

      if (accept && is_mul) begin
        opa_q        <= src_a;
        opb_q        <= src_b;
        mul_sign     <= (op_code == OP_MULT);
        mul_valid_in <= 1'b1;
      end
      if (accept && div_ok) begin
        opa_q        <= src_a;
        opb_q        <= src_b;
        div_sign     <= (op_code == OP_DIV);
        div_valid_in <= 1'b1;
      end
      if (accept && (op_code == OP_MTHI)) hi_q <= src_a;
      if (accept && (op_code == OP_MTLO)) lo_q <= src_a;

      // Div reports quotient on its Hi port; MIPS wants quotient in LO.
      if (div_done) begin
        hi_q <= div_lo;
        lo_q <= div_hi;
      end
      if (mul_done) begin
        hi_q <= mul_hi;
        lo_q <= mul_lo;
      end

      if (state_nxt == DRAIN) begin
        div_valid_in <= 1'b0;
        mul_valid_in <= 1'b0;
      end
      if (aborting) timeout_err <= 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign stall     = op_valid && (state != IDLE);
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign div_src_a = opa_q;
  assign div_src_b = opb_q;
  assign mul_src_a = opa_q;
  assign mul_src_b = opb_q;

endmodule

// File: tb/tb_hilo_controller.sv
// tb/tb_hilo_controller.sv - directed vector bench for hilo_controller with Div/mul unit models
module tb_hilo_controller;

  localparam int TIMEOUT = 64;
  localparam int DIV_LAT = 3;
  localparam int MUL_LAT = 2;
  localparam int BOUND   = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        stall, busy, timeout_err;
  logic [31:0] hi_out, lo_out;
  logic        div_valid_in, div_sign, div_valid_out;
  logic [31:0] div_src_a, div_src_b, div_hi, div_lo;
  logic        mul_valid_in, mul_sign, mul_valid_out;
  logic [31:0] mul_src_a, mul_src_b, mul_hi, mul_lo;

  always #5 clk = ~clk;

  hilo_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .hi_out(hi_out), .lo_out(lo_out), .timeout_err(timeout_err),
    .div_valid_in(div_valid_in), .div_sign(div_sign),
    .div_src_a(div_src_a), .div_src_b(div_src_b),
    .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo),
    .mul_valid_in(mul_valid_in), .mul_sign(mul_sign),
    .mul_src_a(mul_src_a), .mul_src_b(mul_src_b),
    .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  // Unit models: Div gives quotient on Hi, remainder on Lo.
  logic        div_en, div_done_m, mul_done_m;
  int          div_cnt, mul_cnt;
  logic [31:0] q_c, r_c;
  logic [63:0] p_c;

  always_comb begin
    if (div_sign) begin
      q_c = $signed(div_src_a) / $signed(div_src_b);
      r_c = $signed(div_src_a) % $signed(div_src_b);
    end else begin
      q_c = div_src_a / div_src_b;
      r_c = div_src_a % div_src_b;
    end
    if (mul_sign)
      p_c = $signed({{32{mul_src_a[31]}}, mul_src_a}) * $signed({{32{mul_src_b[31]}}, mul_src_b});
    else
      p_c = {32'd0, mul_src_a} * {32'd0, mul_src_b};
  end

  always @(posedge clk) begin
    if (reset || !div_valid_in) begin
      div_valid_out <= 1'b0; div_cnt <= 0; div_done_m <= 1'b0;
      if (reset) begin div_hi <= 32'd0; div_lo <= 32'd0; end
    end else begin
      div_valid_out <= 1'b0;
      if (div_en && !div_done_m) begin
        if (div_cnt == DIV_LAT - 1) begin
          div_valid_out <= 1'b1; div_done_m <= 1'b1; div_hi <= q_c; div_lo <= r_c;
        end else div_cnt <= div_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset || !mul_valid_in) begin
      mul_valid_out <= 1'b0; mul_cnt <= 0; mul_done_m <= 1'b0;
      if (reset) begin mul_hi <= 32'd0; mul_lo <= 32'd0; end
    end else begin
      mul_valid_out <= 1'b0;
      if (!mul_done_m) begin
        if (mul_cnt == MUL_LAT - 1) begin
          mul_valid_out <= 1'b1; mul_done_m <= 1'b1; mul_hi <= p_c[63:32]; mul_lo <= p_c[31:0];
        end else mul_cnt <= mul_cnt + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        e_stall, e_busy;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  vec_t vecs[8];

  // Issue a long op, then present MFLO until it is accepted.
  task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int busy_cyc, output int drain_cyc,
                          output logic [31:0] hi_drain, output logic [31:0] lo_drain);
    int stall_bad;
    busy_cyc = 0; drain_cyc = 0; stall_bad = 0; hi_drain = 'x; lo_drain = 'x;
    op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
    #1;
    check({tag, "_issue_stall"}, 32'(stall), 32'd0);
    tick();
    op_code = 3'd7; src_a = 32'h5A5A_A5A5; src_b = 32'h0;
    #1;
    while (busy && busy_cyc < BOUND) begin
      if (!stall) stall_bad++;
      if (!div_valid_in && !mul_valid_in) begin
        drain_cyc++; hi_drain = hi_out; lo_drain = lo_out;
      end
      busy_cyc++;
      tick();
    end
    check({tag, "_no_hang"}, 32'(busy_cyc < BOUND), 32'd1);
    check({tag, "_stall_while_busy"}, 32'(stall_bad), 32'd0);
    check({tag, "_mflo_accept_stall"}, 32'(stall), 32'd0);
    tick();
    op_valid = 1'b0;
  endtask

  int          bc, dc;
  logic [31:0] hd, ld;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; src_a = 32'd0; src_b = 32'd0; div_en = 1'b1;

    vecs[0] = '{1'b1, 3'd4, 32'h0000_DEAD, 32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h0};
    vecs[1] = '{1'b1, 3'd6, 32'h0,         32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h0};
    vecs[2] = '{1'b1, 3'd5, 32'h0000_1234, 32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};
    vecs[3] = '{1'b1, 3'd2, 32'd55,        32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};
    vecs[4] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};
    vecs[5] = '{1'b1, 3'd7, 32'h0,         32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};
    vecs[6] = '{1'b0, 3'd2, 32'd9,         32'd3,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};
    vecs[7] = '{1'b0, 3'd4, 32'hBEEF,      32'd0,   1'b0, 1'b0, 32'h0000_DEAD, 32'h1234};

    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    check("rst_vin", {30'd0, div_valid_in, mul_valid_in}, 32'd0);
    check("rst_srcs", div_src_a | div_src_b, 32'd0);

    foreach (vecs[i]) begin
      op_valid = vecs[i].v; op_code = vecs[i].op; src_a = vecs[i].a; src_b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      tick();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_hi", i), hi_out, vecs[i].e_hi);
      check($sformatf("vec%0d_lo", i), lo_out, vecs[i].e_lo);
    end
    op_valid = 1'b0;

    // DIVU 100/7: 5 busy cycles (issue, 3 Div cycles, DRAIN), one DRAIN with valid_in low.
    run_long("divu", 3'd3, 32'd100, 32'd7, bc, dc, hd, ld);
    check("divu_busy_cycles", 32'(bc), 32'd5);
    check("divu_drain_cycles", 32'(dc), 32'd1);
    check("divu_lo_at_drain", ld, 32'd14);
    check("divu_lo", lo_out, 32'd14);
    check("divu_hi", hi_out, 32'd2);

    run_long("div", 3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc, hd, ld);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    check("div_hi_at_drain", hd, 32'hFFFF_FFFF);

    // MULT: 4 busy cycles (issue, 2 mul cycles, DRAIN).
    run_long("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, bc, dc, hd, ld);
    check("mult_busy_cycles", 32'(bc), 32'd4);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);

    run_long("multu", 3'd1, 32'h0001_0000, 32'h0001_0000, bc, dc, hd, ld);
    check("multu_hi", hi_out, 32'h0000_0001);
    check("multu_lo", lo_out, 32'h0000_0000);

    run_long("multu_big", 3'd1, 32'hFFFF_FFFE, 32'd3, bc, dc, hd, ld);
    check("multu_big_hi", hi_out, 32'h0000_0002);
    check("multu_big_lo", lo_out, 32'hFFFF_FFFA);

    // Watchdog: TIMEOUT busy cycles plus DRAIN, HI/LO untouched.
    div_en = 1'b0;
    op_valid = 1'b1; op_code = 3'd2; src_a = 32'd5; src_b = 32'd1;
    tick();
    op_valid = 1'b0; src_b = 32'd77;
    #1;
    check("wdog_div_sign", 32'(div_sign), 32'd1);
    check("wdog_src_b_held", div_src_b, 32'd1);
    bc = 0;
    while (busy && bc < BOUND) begin bc++; tick(); end
    check("wdog_busy_cycles", 32'(bc), 32'(TIMEOUT + 1));
    check("wdog_terr", 32'(timeout_err), 32'd1);
    check("wdog_hi", hi_out, 32'h0000_0002);
    check("wdog_lo", lo_out, 32'hFFFF_FFFA);

    // Reset in the middle of DIV_BUSY.
    op_valid = 1'b1; op_code = 3'd3; src_a = 32'd8; src_b = 32'd2;
    tick();
    op_valid = 1'b0;
    tick(); tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hi", hi_out, 32'd0);
    check("mid_rst_lo", lo_out, 32'd0);
    check("mid_rst_vin", 32'(div_valid_in), 32'd0);
    check("mid_rst_terr", 32'(timeout_err), 32'd0);
    div_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
